// File: rtl/seq_div_pkg.sv
// Shared types and helpers for the sequential restoring divider.
// Operand helpers work on a fixed wide container; callers extend and truncate.
package seq_div_pkg;

  localparam int DIV_MAX_W = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } div_state_t;

  // Caller sign-extends the operand in signed mode so the MSB of the container is its sign.
  function automatic logic [DIV_MAX_W-1:0] abs_if_signed(input logic [DIV_MAX_W-1:0] value,
                                                         input logic               signed_mode);
    logic [DIV_MAX_W-1:0] res;
    res = value;
    if (signed_mode && value[DIV_MAX_W-1]) res = -value;
    return res;
  endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration: shift {P,A} left, trial-subtract |M|.
// Zero latency; no flow control.
module div_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] p,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH-1:0] p_nxt,
  output logic [WIDTH-1:0] a_nxt
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // P < |M| always holds, so the shifted value fits WIDTH+1 bits and trial[WIDTH] is its sign.
  always_comb begin
    shifted = {p, a[WIDTH-1]};
    trial   = shifted - {1'b0, m};
    if (!trial[WIDTH]) begin
      p_nxt = trial[WIDTH-1:0];
      a_nxt = {a[WIDTH-2:0], 1'b1};
    end else begin
      p_nxt = shifted[WIDTH-1:0];
      a_nxt = {a[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/seq_div.sv
// WIDTH-bit signed/unsigned restoring divider, one quotient bit per clock.
// Latency WIDTH+1 cycles accept-to-done (1 on divide-by-zero); start ignored unless ready.
module seq_div
  import seq_div_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH+1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  div_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] p, a, m_abs, dvd;
  logic             neg_q, neg_r, dbz_sel, ovf_sel;

  logic [DIV_MAX_W-1:0] q_ext, m_ext;
  logic [WIDTH-1:0]     q_mag, m_mag;
  logic [WIDTH-1:0]     p_nxt, a_nxt;

  always_comb begin
    q_ext = DIV_MAX_W'(dividend);
    m_ext = DIV_MAX_W'(divisor);
    if (signed_mode) begin
      q_ext = DIV_MAX_W'($signed(dividend));
      m_ext = DIV_MAX_W'($signed(divisor));
    end
    q_mag = WIDTH'(abs_if_signed(q_ext, signed_mode));
    m_mag = WIDTH'(abs_if_signed(m_ext, signed_mode));
  end

  div_step #(.WIDTH(WIDTH)) u_step (
    .p     (p),
    .a     (a),
    .m     (m_abs),
    .p_nxt (p_nxt),
    .a_nxt (a_nxt)
  );

  assign ready = (state == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      p           <= '0;
      a           <= '0;
      m_abs       <= '0;
      dvd         <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      dbz_sel     <= 1'b0;
      ovf_sel     <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            dvd     <= dividend;
            a       <= q_mag;
            m_abs   <= m_mag;
            p       <= '0;
            cnt     <= CNT_W'(WIDTH);
            neg_q   <= signed_mode & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            neg_r   <= signed_mode & dividend[WIDTH-1];
            dbz_sel <= (divisor == '0);
            ovf_sel <= signed_mode && (dividend == MOST_NEG) && (divisor == '1);
            state   <= (divisor == '0) ? FIX : CALC;
          end
        end
        CALC: begin
          p   <= p_nxt;
          a   <= a_nxt;
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) state <= FIX;
        end
        FIX: begin
          done        <= 1'b1;
          div_by_zero <= dbz_sel;
          overflow    <= ovf_sel;
          if (dbz_sel) begin
            quotient  <= '1;
            remainder <= dvd;
          end else if (ovf_sel) begin
            // Most-negative / -1 wraps back to the dividend.
            quotient  <= dvd;
            remainder <= '0;
          end else begin
            quotient  <= neg_q ? -a : a;
            remainder <= neg_r ? -p : p;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
